// File: rtl/sm_run_ctrl_if.sv
// Run-control bundle: host command/breakpoint inputs and sequencer status outputs.
// The master side drives commands; the slave side is the sequencer.
interface sm_run_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [3:0]       devide;
    logic             cmd_halt;
    logic             cmd_run;
    logic             cmd_step;
    logic             cmd_count;
    logic [CNT_W-1:0] count;
    logic             bp_en;
    logic [31:0]      bp_addr;
    logic [31:0]      pc;
    logic             cpu_en;
    logic [1:0]       state;
    logic             halted;
    logic             bp_hit;
    logic [CNT_W-1:0] remaining;

    modport master (
        output devide, cmd_halt, cmd_run, cmd_step, cmd_count, count,
               bp_en, bp_addr, pc,
        input  cpu_en, state, halted, bp_hit, remaining
    );

    modport slave (
        input  devide, cmd_halt, cmd_run, cmd_step, cmd_count, count,
               bp_en, bp_addr, pc,
        output cpu_en, state, halted, bp_hit, remaining
    );
endinterface

// File: rtl/sm_run_ctrl.sv
// Run-control sequencer for the schoolMIPS core: prescaled tick plus a
// halt/run/step/run-N state machine with a sticky PC breakpoint.
module sm_run_ctrl #(
    parameter int unsigned SHIFT = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    sm_run_ctrl_if.slave bus
);

    localparam int unsigned PRE_W = SHIFT + 16;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_COUNT = 2'd3
    } state_e;

    state_e           state_q,  state_d;
    logic [PRE_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] rem_q,    rem_d;
    logic             cpu_en_q, cpu_en_d;
    logic             bp_hit_q, bp_hit_d;
    logic             armed_q,  armed_d;
    logic             halted_q, halted_d;

    logic [PRE_W-1:0] lim_c;
    logic             tick_c;
    logic             bp_match_c;
    logic             start_c;

    // Tick limit 2^(SHIFT+devide)-1; >= keeps a mid-count devide decrease safe.
    assign lim_c      = (PRE_W'(1) << (SHIFT + 32'(bus.devide))) - PRE_W'(1);
    assign tick_c     = (cnt_q >= lim_c);
    assign bp_match_c = armed_q && bus.bp_en && (bus.pc == bus.bp_addr);

    // Any accepted start command clears the sticky hit and disarms the breakpoint.
    assign start_c = (state_q == ST_HALT) && !bus.cmd_halt &&
                     (bus.cmd_run || (bus.cmd_count && (bus.count != '0)) ||
                      (!bus.cmd_count && bus.cmd_step));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        cpu_en_d = 1'b0;
        bp_hit_d = bp_hit_q;
        armed_d  = armed_q;

        if (start_c) begin
            bp_hit_d = 1'b0;
            armed_d  = 1'b0;
        end

        unique case (state_q)
            ST_HALT: begin
                cnt_d = '0;
                if (!bus.cmd_halt) begin
                    if (bus.cmd_run) begin
                        state_d = ST_RUN;
                    end else if (bus.cmd_count) begin
                        // A zero count is a no-op and does not fall through to step.
                        if (bus.count != '0) begin
                            state_d = ST_COUNT;
                            rem_d   = bus.count;
                        end
                    end else if (bus.cmd_step) begin
                        state_d = ST_STEP;
                    end
                end
            end

            ST_RUN: begin
                if (bus.cmd_halt) begin
                    state_d = ST_HALT;
                    cnt_d   = '0;
                    rem_d   = '0;
                end else if (!tick_c) begin
                    cnt_d = cnt_q + PRE_W'(1);
                end else if (bp_match_c) begin
                    state_d  = ST_HALT;
                    cnt_d    = '0;
                    bp_hit_d = 1'b1;
                    rem_d    = '0;
                end else begin
                    cnt_d    = '0;
                    cpu_en_d = 1'b1;
                    armed_d  = 1'b1;
                end
            end

            ST_STEP: begin
                // A step ignores the breakpoint so it always moves off it.
                if (bus.cmd_halt) begin
                    state_d = ST_HALT;
                    cnt_d   = '0;
                    rem_d   = '0;
                end else if (!tick_c) begin
                    cnt_d = cnt_q + PRE_W'(1);
                end else begin
                    state_d  = ST_HALT;
                    cnt_d    = '0;
                    cpu_en_d = 1'b1;
                end
            end

            ST_COUNT: begin
                if (bus.cmd_halt) begin
                    state_d = ST_HALT;
                    cnt_d   = '0;
                    rem_d   = '0;
                end else if (!tick_c) begin
                    cnt_d = cnt_q + PRE_W'(1);
                end else if (bp_match_c) begin
                    state_d  = ST_HALT;
                    cnt_d    = '0;
                    bp_hit_d = 1'b1;
                    rem_d    = '0;
                end else begin
                    cnt_d    = '0;
                    cpu_en_d = 1'b1;
                    armed_d  = 1'b1;
                    rem_d    = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_HALT;
                    end
                end
            end

            default: begin
                state_d = ST_HALT;
                cnt_d   = '0;
                rem_d   = '0;
            end
        endcase

        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_HALT;
            cnt_q    <= '0;
            rem_q    <= '0;
            cpu_en_q <= 1'b0;
            bp_hit_q <= 1'b0;
            armed_q  <= 1'b0;
            halted_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            cpu_en_q <= cpu_en_d;
            bp_hit_q <= bp_hit_d;
            armed_q  <= armed_d;
            halted_q <= halted_d;
        end
    end

    assign bus.cpu_en    = cpu_en_q;
    assign bus.state     = state_q;
    assign bus.halted    = halted_q;
    assign bus.bp_hit    = bp_hit_q;
    assign bus.remaining = rem_q;

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Directed bench for sm_run_ctrl: expected cpu_en pulses are queued at command
// time and matched (cycle and PC) as the DUT produces them.
module tb_sm_run_ctrl;

    localparam int unsigned CNT_W = 16;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        bit          has_pc;
    } pulse_t;

    logic   clk = 1'b0;
    logic   rst_n;
    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;
    int     e0;
    pulse_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sm_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

    sm_run_ctrl #(.SHIFT(0), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [31:0] p, input bit hp);
        pulse_t e;
        e.cyc    = c;
        e.pc     = p;
        e.has_pc = hp;
        exp_q.push_back(e);
    endtask

    // One clock; sample at the falling edge and score any pulse.
    task automatic step_cyc();
        pulse_t e;
        @(posedge clk);
        @(negedge clk);
        if (bus.cpu_en === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_pulse: observed pulse at cycle %0d expected none", cyc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                if (e.has_pc) chk("pulse_pc", bus.pc, e.pc);
            end
            bus.pc = bus.pc + 32'd4;
        end else if (exp_q.size() != 0) begin
            checks++;
            assert (exp_q[0].cyc > cyc) else begin
                failures++;
                $error("FAIL missing_pulse: observed none at cycle %0d expected pulse", cyc);
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step_cyc();
    endtask

    task automatic issue(input bit h, input bit r, input bit s, input bit c,
                         input logic [CNT_W-1:0] n);
        bus.cmd_halt  = h;
        bus.cmd_run   = r;
        bus.cmd_step  = s;
        bus.cmd_count = c;
        bus.count     = n;
        step_cyc();
        bus.cmd_halt  = 1'b0;
        bus.cmd_run   = 1'b0;
        bus.cmd_step  = 1'b0;
        bus.cmd_count = 1'b0;
        bus.count     = '0;
        e0 = cyc;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.devide    = 4'd0;
        bus.cmd_halt  = 1'b0;
        bus.cmd_run   = 1'b0;
        bus.cmd_step  = 1'b0;
        bus.cmd_count = 1'b0;
        bus.count     = '0;
        bus.bp_en     = 1'b0;
        bus.bp_addr   = 32'h0;
        bus.pc        = 32'h0;

        @(negedge clk);
        chk("rst_state",     32'(bus.state),     32'd0);
        chk("rst_halted",    32'(bus.halted),    32'd1);
        chk("rst_cpu_en",    32'(bus.cpu_en),    32'd0);
        chk("rst_bp_hit",    32'(bus.bp_hit),    32'd0);
        chk("rst_remaining", 32'(bus.remaining), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(2);

        // Single step with L=0
        issue(1'b0, 1'b0, 1'b1, 1'b0, '0);
        push(e0 + 1, 32'h0, 1'b0);
        chk("step_state", 32'(bus.state), 32'd2);
        step_cyc();
        chk("step_state_after",  32'(bus.state),  32'd0);
        chk("step_halted_after", 32'(bus.halted), 32'd1);
        run(3);

        // Free run with L=3, halt accepted at E10
        bus.devide = 4'd2;
        issue(1'b0, 1'b1, 1'b0, 1'b0, '0);
        push(e0 + 4, 32'h0, 1'b0);
        push(e0 + 8, 32'h0, 1'b0);
        chk("run_state", 32'(bus.state), 32'd1);
        run(9);
        issue(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("run_halt_state", 32'(bus.state), 32'd0);
        run(6);

        // Run-N with count=3, L=0
        bus.devide = 4'd0;
        issue(1'b0, 1'b0, 1'b0, 1'b1, CNT_W'(3));
        push(e0 + 1, 32'h0, 1'b0);
        push(e0 + 2, 32'h0, 1'b0);
        push(e0 + 3, 32'h0, 1'b0);
        chk("cnt_state", 32'(bus.state),     32'd3);
        chk("cnt_rem3",  32'(bus.remaining), 32'd3);
        step_cyc();
        chk("cnt_rem2",  32'(bus.remaining), 32'd2);
        step_cyc();
        chk("cnt_rem1",  32'(bus.remaining), 32'd1);
        step_cyc();
        chk("cnt_rem0",  32'(bus.remaining), 32'd0);
        chk("cnt_done_state", 32'(bus.state), 32'd0);
        run(2);

        // Run-N with count=0 is a no-op
        issue(1'b0, 1'b0, 1'b0, 1'b1, '0);
        chk("cnt0_state", 32'(bus.state),     32'd0);
        chk("cnt0_rem",   32'(bus.remaining), 32'd0);
        run(3);

        // Breakpoint at 0x10 with pc advancing by 4 per pulse
        bus.pc      = 32'h0;
        bus.bp_en   = 1'b1;
        bus.bp_addr = 32'h10;
        issue(1'b0, 1'b1, 1'b0, 1'b0, '0);
        push(e0 + 1, 32'h0, 1'b1);
        push(e0 + 2, 32'h4, 1'b1);
        push(e0 + 3, 32'h8, 1'b1);
        push(e0 + 4, 32'hC, 1'b1);
        run(5);
        chk("bp_cpu_en", 32'(bus.cpu_en), 32'd0);
        chk("bp_hit",    32'(bus.bp_hit), 32'd1);
        chk("bp_state",  32'(bus.state),  32'd0);
        chk("bp_halted", 32'(bus.halted), 32'd1);
        run(2);
        issue(1'b0, 1'b1, 1'b0, 1'b0, '0);
        push(e0 + 1, 32'h10, 1'b1);
        chk("bp_resume_hit",   32'(bus.bp_hit), 32'd0);
        chk("bp_resume_state", 32'(bus.state),  32'd1);
        step_cyc();
        issue(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("halt_on_tick_cpu_en", 32'(bus.cpu_en), 32'd0);
        chk("halt_on_tick_state",  32'(bus.state),  32'd0);
        bus.bp_en = 1'b0;
        run(3);

        // Simultaneous halt+run in HALT stays halted
        issue(1'b1, 1'b1, 1'b0, 1'b0, '0);
        chk("halt_run_state", 32'(bus.state), 32'd0);
        run(3);

        // Step during RUN is ignored; halt before the first tick
        bus.devide = 4'd2;
        issue(1'b0, 1'b1, 1'b0, 1'b0, '0);
        step_cyc();
        issue(1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("step_in_run_state", 32'(bus.state),     32'd1);
        chk("step_in_run_rem",   32'(bus.remaining), 32'd0);
        issue(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("early_halt_state", 32'(bus.state), 32'd0);
        run(6);

        // Asynchronous reset mid run-N with remaining=5
        bus.devide = 4'd0;
        issue(1'b0, 1'b0, 1'b0, 1'b1, CNT_W'(8));
        push(e0 + 1, 32'h0, 1'b0);
        push(e0 + 2, 32'h0, 1'b0);
        push(e0 + 3, 32'h0, 1'b0);
        run(3);
        chk("pre_rst_rem",    32'(bus.remaining), 32'd5);
        chk("pre_rst_cpu_en", 32'(bus.cpu_en),    32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cpu_en",    32'(bus.cpu_en),    32'd0);
        chk("arst_state",     32'(bus.state),     32'd0);
        chk("arst_halted",    32'(bus.halted),    32'd1);
        chk("arst_bp_hit",    32'(bus.bp_hit),    32'd0);
        chk("arst_remaining", 32'(bus.remaining), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(5);
        chk("post_rst_state", 32'(bus.state), 32'd0);
        chk("pulses_left",    32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
